// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array host driver.
// Covers the matrix geometry, the byte width, the buffer depths and the controller states.
package sa_pkg;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int OP_BYTES  = 2 * N * N;
    localparam int RES_BYTES = N * N;

    typedef enum logic [2:0] {
        IDLE,
        EN,
        LOAD,
        WAIT,
        CAPTURE,
        DONE
    } sa_state_t;

endpackage

// File: rtl/sa_byte_regfile.sv
// Byte-wide register file with one synchronous write port and one asynchronous read port.
// A synchronous reset clears every entry to zero.
module sa_byte_regfile
    import sa_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sa_host_driver.sv
// Host-side driver for the systolic-array coprocessor.
// It streams 32 operand bytes out to the coprocessor and collects the 16 result bytes that come back.
module sa_host_driver
    import sa_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cop_en,
    output logic [7:0] cop_shift_in,
    input  logic [7:0] cop_shift_out,
    input  logic       cop_ack
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    sa_state_t     state, state_next;
    logic [5:0]    load_cnt, load_cnt_next;
    logic [7:0]    wait_cnt, wait_cnt_next;
    logic [3:0]    cap_idx, cap_idx_next;
    logic          err_q, err_next;

    logic          op_we;
    logic [DW-1:0] op_rdata;
    logic          res_we;
    logic [3:0]    res_waddr;

    // Operand bytes may only change while no run is in flight.
    assign op_we = wr_en && (state == IDLE);

    sa_byte_regfile #(.DEPTH(OP_BYTES)) u_operands (
        .clk   (clk),
        .rst   (rst),
        .we    (op_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (load_cnt[4:0]),
        .rdata (op_rdata)
    );

    sa_byte_regfile #(.DEPTH(RES_BYTES)) u_results (
        .clk   (clk),
        .rst   (rst),
        .we    (res_we),
        .waddr (res_waddr),
        .wdata (cop_shift_out),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            load_cnt <= '0;
            wait_cnt <= '0;
            cap_idx  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            load_cnt <= load_cnt_next;
            wait_cnt <= wait_cnt_next;
            cap_idx  <= cap_idx_next;
            err_q    <= err_next;
        end
    end

    always_comb begin
        state_next    = state;
        load_cnt_next = load_cnt;
        wait_cnt_next = wait_cnt;
        cap_idx_next  = cap_idx;
        err_next      = err_q;
        res_we        = 1'b0;
        res_waddr     = cap_idx;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = EN;
                    err_next      = 1'b0;
                    load_cnt_next = '0;
                    wait_cnt_next = '0;
                    cap_idx_next  = '0;
                end
            end
            EN: begin
                state_next = LOAD;
            end
            LOAD: begin
                if (load_cnt == 6'd31) begin
                    state_next    = WAIT;
                    load_cnt_next = '0;
                    wait_cnt_next = '0;
                end else begin
                    load_cnt_next = load_cnt + 6'd1;
                end
            end
            // An ack arriving on the last allowed WAIT cycle still wins over the timeout.
            WAIT: begin
                if (cop_ack) begin
                    res_we       = 1'b1;
                    res_waddr    = 4'd0;
                    cap_idx_next = 4'd1;
                    state_next   = CAPTURE;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            CAPTURE: begin
                if (cop_ack) begin
                    res_we = 1'b1;
                    if (cap_idx == 4'd15) begin
                        cap_idx_next = '0;
                        state_next   = DONE;
                    end else begin
                        cap_idx_next = cap_idx + 4'd1;
                    end
                end else begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign cop_en       = (state == EN);
    assign cop_shift_in = (state == LOAD) ? op_rdata : '0;
    assign err          = err_q;

endmodule

// File: tb/tb_sa_host_driver.sv
// Randomised bench for sa_host_driver.
// A behavioural coprocessor computes C = A x B from the host's operand image and answers each run.
module tb_sa_host_driver;

    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       err;
    logic       cop_en;
    logic [7:0] cop_shift_in;
    logic [7:0] cop_shift_out;
    logic       cop_ack;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] op_model  [32];
    logic [7:0] res_model [16];

    sa_host_driver #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .cop_en        (cop_en),
        .cop_shift_in  (cop_shift_in),
        .cop_shift_out (cop_shift_out),
        .cop_ack       (cop_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before the run completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeOperand(input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr[4:0];
        wr_data = data;
        tick();
        wr_en   = 1'b0;
        op_model[addr] = data;
    endtask

    task automatic loadRandom();
        for (int i = 0; i < 32; i++) begin
            writeOperand(i, 8'($urandom));
        end
    endtask

    task automatic checkResults(input string tag);
        for (int j = 0; j < 16; j++) begin
            rd_addr = j[3:0];
            #1;
            checkOutput(tag, rd_data, res_model[j]);
        end
    endtask

    // One complete run: the coprocessor answers after ack_delay WAIT cycles with ack_num
    // bytes of A x B. inject_at and reset_at name the LOAD byte at which to disturb the
    // run (-1 for none).
    task automatic applyStimulus(input int ack_delay, input int ack_num,
                                 input int inject_at, input int reset_at);
        logic [7:0] cbytes [16];
        int         sum;
        int         done_at;
        bit         got_done;
        bit         never_ack;
        bit         exp_err;
        int         exp_done;

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sum = 0;
                for (int k = 0; k < 4; k++) begin
                    sum += int'(op_model[r*4+k]) * int'(op_model[16+c*4+k]);
                end
                cbytes[r*4+c] = sum[7:0];
            end
        end
        never_ack = (ack_num == 0) || (ack_delay > TIMEOUT);
        exp_err   = never_ack || (ack_num < 16);
        exp_done  = never_ack ? TIMEOUT + 1
                              : ack_delay + ack_num + ((ack_num < 16) ? 1 : 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("en_busy", busy, 1);
        checkOutput("en_pulse", cop_en, 1);
        checkOutput("en_err_clear", err, 0);
        checkOutput("en_shift_zero", cop_shift_in, 0);
        cop_ack       = 1'($urandom);
        cop_shift_out = 8'($urandom);
        tick();

        for (int i = 0; i < 32; i++) begin
            checkOutput("load_byte", cop_shift_in, op_model[i]);
            checkOutput("load_en_low", cop_en, 0);
            if (i == reset_at) begin
                cop_ack = 1'b0;
                rst     = 1'b1;
                tick();
                rst     = 1'b0;
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_shift", cop_shift_in, 0);
                checkOutput("rst_en", cop_en, 0);
                checkOutput("rst_done", done, 0);
                checkOutput("rst_err", err, 0);
                for (int j = 0; j < 32; j++) op_model[j] = 8'h00;
                for (int j = 0; j < 16; j++) res_model[j] = 8'h00;
                return;
            end
            cop_ack       = 1'($urandom);
            cop_shift_out = 8'($urandom);
            if (i == inject_at) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 5'd31;
                wr_data = ~op_model[31];
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
        end

        got_done = 1'b0;
        done_at  = -1;
        for (int cyc = 0; cyc < TIMEOUT + 40; cyc++) begin
            if (done) begin
                got_done = 1'b1;
                done_at  = cyc;
                break;
            end
            checkOutput("wait_shift_zero", cop_shift_in, 0);
            checkOutput("wait_busy", busy, 1);
            if (!never_ack && cyc >= ack_delay && cyc < ack_delay + ack_num) begin
                cop_ack       = 1'b1;
                cop_shift_out = cbytes[cyc - ack_delay];
            end else begin
                cop_ack       = 1'b0;
                cop_shift_out = 8'($urandom);
            end
            tick();
        end
        checkOutput("done_seen", got_done, 1);
        checkOutput("done_cycle", done_at, exp_done);
        checkOutput("done_err", err, exp_err);
        checkOutput("done_shift_zero", cop_shift_in, 0);

        cop_ack = 1'b0;
        tick();
        checkOutput("after_done_low", done, 0);
        checkOutput("after_busy_low", busy, 0);
        checkOutput("after_err_sticky", err, exp_err);

        if (!never_ack) begin
            for (int j = 0; j < ack_num; j++) res_model[j] = cbytes[j];
        end
        checkResults("result_byte");
    endtask

    initial begin
        int nack;

        rst           = 1'b1;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        start         = 1'b0;
        rd_addr       = '0;
        cop_shift_out = '0;
        cop_ack       = 1'b0;
        for (int j = 0; j < 32; j++) op_model[j] = 8'h00;
        for (int j = 0; j < 16; j++) res_model[j] = 8'h00;
        repeat (3) tick();
        rst = 1'b0;

        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_cop_en", cop_en, 0);
        checkOutput("reset_shift", cop_shift_in, 0);
        checkResults("reset_result");

        // A = 1..16, B = identity, so the result must equal A.
        for (int i = 0; i < 16; i++) writeOperand(i, 8'(i + 1));
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                writeOperand(16 + c*4 + r, (r == c) ? 8'd1 : 8'd0);
            end
        end
        applyStimulus(3, 16, -1, -1);
        for (int i = 0; i < 16; i++) begin
            rd_addr = i[3:0];
            #1;
            checkOutput("identity_c", rd_data, i + 1);
        end

        applyStimulus(TIMEOUT + 100, 0, -1, -1);

        loadRandom();
        applyStimulus($urandom_range(0, 10), 16, -1, -1);

        loadRandom();
        applyStimulus(2, 7, -1, -1);

        applyStimulus(0, 16, 5, -1);

        applyStimulus(TIMEOUT, 16, -1, -1);

        loadRandom();
        applyStimulus(0, 16, -1, 10);
        checkResults("post_reset_result");
        applyStimulus(4, 16, -1, -1);

        for (int it = 0; it < 8; it++) begin
            loadRandom();
            nack = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 16;
            applyStimulus($urandom_range(0, 30), nack, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sa_host_driver.md
SA_HOST_DRIVER -- requirements
Module: sa_host_driver

Interface
REQ-001 Parameter: TIMEOUT, 255, maximum WAIT cycles for cop_ack before error.
REQ-002 Port: clk  in  1  single clock; all logic rising-edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: wr_en  in  1  host operand write strobe.
REQ-005 Port: wr_addr  in  5  0-15 = A[r][c] at r*4+c; 16-31 = B[r][c] at 16+c*4+r (column-major).
REQ-006 Port: wr_data  in  8  operand byte.
REQ-007 Port: start  in  1  one-cycle request to run one multiply.
REQ-008 Port: rd_addr  in  4  result index, C[r][c] at r*4+c.
REQ-009 Port: rd_data  out  8  result byte, combinational read of result buffer.
REQ-010 Port: busy  out  1  high from accepted start until done.
REQ-011 Port: done  out  1  one-cycle pulse at end of run.
REQ-012 Port: err  out  1  sticky error flag, cleared by next accepted start.
REQ-013 Port: cop_en  out  1  coprocessor start pulse.
REQ-014 Port: cop_shift_in  out  8  byte stream to coprocessor.
REQ-015 Port: cop_shift_out  in  8  result byte stream from coprocessor.
REQ-016 Port: cop_ack  in  1  coprocessor result-valid qualifier.

Function
REQ-017 States SHALL be IDLE, EN, LOAD, WAIT, CAPTURE, DONE.
REQ-018 IDLE: start=1 -> EN, busy=1 next cycle, err cleared; start while busy ignored.
REQ-019 wr_en SHALL write operand buffer only in IDLE; writes in other states are dropped.
REQ-020 EN: cop_en=1 for exactly one cycle, then LOAD.
REQ-021 LOAD: 32 consecutive cycles, cop_shift_in = operand byte 0..31 in address order (A row-major, then B column-major); 6-bit counter; after byte 31 -> WAIT.
REQ-022 cop_shift_in SHALL be 8'h00 outside LOAD.
REQ-023 cop_ack during EN or LOAD SHALL be ignored.
REQ-024 WAIT: 8-bit counter from 0; cop_ack=1 -> CAPTURE, same-cycle byte captured as C index 0; counter reaching TIMEOUT without ack -> err=1, DONE.
REQ-025 CAPTURE: each cycle with cop_ack=1 stores cop_shift_out at next index; after index 15 stored -> DONE.
REQ-026 cop_ack=0 in CAPTURE before 16 bytes -> err=1, DONE; bytes already stored kept.
REQ-027 DONE: done=1 one cycle, busy=0 next cycle, -> IDLE.
REQ-028 Result buffer SHALL hold values until overwritten by a later CAPTURE; reads allowed in any state.
REQ-029 Unsigned 8-bit data throughout; no arithmetic on data bytes.

Reset
REQ-030 rst SHALL force IDLE, busy=0, done=0, err=0, cop_en=0, cop_shift_in=0, counters=0, in any state including mid-LOAD/CAPTURE.
REQ-031 Operand and result buffers SHALL reset to 0.

Structure
REQ-032 Shared package sa_pkg SHALL hold state enum, N=4, DW=8, OP_BYTES=32, RES_BYTES=16.
REQ-033 One sub-module sa_byte_regfile (parameterised depth, 1 sync write, 1 async read) SHALL implement both buffers.

Verification
REQ-034 Write A=1..16, B=identity, start; model returns 16 ack bytes C=A -> cop_shift_in sequence 1..16 then B bytes, rd_data[i]=i+1, done once, err=0.
REQ-035 Model never asserts ack -> err=1 and done exactly TIMEOUT+1 cycles after entering WAIT, cop_shift_in=0.
REQ-036 ack drops after 7 bytes -> err=1, done pulse, indices 0-6 valid, 7-15 keep prior values.
REQ-037 start and wr_en pulsed during LOAD -> no restart, operand bytes unchanged, stream unaffected.
REQ-038 rst asserted at LOAD byte 10 -> next cycle IDLE, busy=0, cop_shift_in=0; new start reloads from byte 0 with operands all 0.
